// File: rtl/perip_tick_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divider producing
// single-cycle enable pulses in continuous, one-shot or burst mode.
module perip_tick_gen #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_burst,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] clken,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] done
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_CONT    = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_BURST   = 2'd3;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    // A programmed burst length of zero stands for the full 2^CNT_W pulses.
    function automatic logic [CNT_W:0] burst_target(input logic [CNT_W-1:0] b);
        return (b == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, b};
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t            state_q, state_d;
        logic [DIV_W-1:0]  sdiv_q, sdiv_d, adiv_q, adiv_d, cnt_q, cnt_d;
        logic [1:0]        smode_q, smode_d, amode_q, amode_d;
        logic [CNT_W-1:0]  sburst_q, sburst_d, aburst_q, aburst_d;
        logic [CNT_W:0]    pcnt_q, pcnt_d, pcnt_inc;
        logic              clken_q, clken_d, done_q, done_d;
        logic              cfg_hit;
        logic [DIV_W-1:0]  eff_div;
        logic [1:0]        eff_mode;
        logic [CNT_W-1:0]  eff_burst;

        // Same-edge write bypass: a start sees the value being written this edge.
        assign cfg_hit   = cfg_wr && (cfg_ch == CH_W'(g));
        assign eff_div   = cfg_hit ? cfg_div   : sdiv_q;
        assign eff_mode  = cfg_hit ? cfg_mode  : smode_q;
        assign eff_burst = cfg_hit ? cfg_burst : sburst_q;
        assign pcnt_inc  = pcnt_q + 1'b1;

        always_comb begin
            state_d  = state_q;
            sdiv_d   = eff_div;
            smode_d  = eff_mode;
            sburst_d = eff_burst;
            adiv_d   = adiv_q;
            amode_d  = amode_q;
            aburst_d = aburst_q;
            cnt_d    = cnt_q;
            pcnt_d   = pcnt_q;
            clken_d  = 1'b0;
            done_d   = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start[g] && !stop[g] && (eff_mode != MODE_OFF)) begin
                        state_d  = S_RUN;
                        adiv_d   = eff_div;
                        amode_d  = eff_mode;
                        aburst_d = eff_burst;
                        cnt_d    = eff_div;
                        pcnt_d   = '0;
                    end
                end
                S_RUN: begin
                    if (stop[g]) begin
                        state_d = S_IDLE;
                    end else if (start[g]) begin
                        adiv_d   = eff_div;
                        amode_d  = eff_mode;
                        aburst_d = eff_burst;
                        cnt_d    = eff_div;
                        pcnt_d   = '0;
                        if (eff_mode == MODE_OFF) state_d = S_IDLE;
                    end else if (cnt_q == '0) begin
                        clken_d = 1'b1;
                        cnt_d   = adiv_q;
                        pcnt_d  = pcnt_inc;
                        case (amode_q)
                            // Continuous mode tracks divider writes from the next period.
                            MODE_CONT: begin
                                adiv_d = sdiv_q;
                                cnt_d  = sdiv_q;
                            end
                            MODE_ONESHOT: begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                            MODE_BURST: begin
                                if (pcnt_inc == burst_target(aburst_q)) begin
                                    done_d  = 1'b1;
                                    state_d = S_IDLE;
                                end
                            end
                            default: begin
                                clken_d = 1'b0;
                                state_d = S_IDLE;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge PCLK) begin
            if (!PRESETn) begin
                state_q  <= S_IDLE;
                sdiv_q   <= '0;
                smode_q  <= MODE_OFF;
                sburst_q <= '0;
                adiv_q   <= '0;
                amode_q  <= MODE_OFF;
                aburst_q <= '0;
                cnt_q    <= '0;
                pcnt_q   <= '0;
                clken_q  <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                sdiv_q   <= sdiv_d;
                smode_q  <= smode_d;
                sburst_q <= sburst_d;
                adiv_q   <= adiv_d;
                amode_q  <= amode_d;
                aburst_q <= aburst_d;
                cnt_q    <= cnt_d;
                pcnt_q   <= pcnt_d;
                clken_q  <= clken_d;
                done_q   <= done_d;
            end
        end

        assign clken[g]  = clken_q;
        assign done[g]   = done_q;
        assign active[g] = (state_q == S_RUN);
    end

endmodule

// File: doc/perip_tick_gen.md
# perip_tick_gen

Parametrised multi-channel clock-enable generator for the peripheral subsystem. Each channel produces single-cycle enable pulses at a programmable divide ratio in continuous, one-shot or burst mode. Outputs drive the `*_clken*` inputs of timer, dualtimer and watchdog instances, replacing fixed per-peripheral enable wiring. Channel count and counter widths scale by parameter.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `DIV_W`, 16: divider width; pulse period is `div+1` PCLK cycles.
- `CNT_W`, 8: burst-length counter width.
- `CH_W`, `$clog2(NUM_CH)` with a minimum of 1: derived channel-index width.
- `PCLK`  in  1  clock; all logic is on the rising edge.
- `PRESETn`  in  1  reset; synchronous, active-low.
- `cfg_wr`  in  1  config write strobe, sampled every edge.
- `cfg_ch`  in  CH_W  target channel; a write with `cfg_ch >= NUM_CH` is ignored.
- `cfg_div`  in  DIV_W  divide value.
- `cfg_mode`  in  2  0=OFF, 1=CONT, 2=ONESHOT, 3=BURST.
- `cfg_burst`  in  CNT_W  BURST pulse count; 0 means 2^CNT_W.
- `start`  in  NUM_CH  per-channel start request, level-sampled.
- `stop`  in  NUM_CH  per-channel stop request, level-sampled.
- `clken`  out  NUM_CH  registered enable pulses.
- `active`  out  NUM_CH  channel in RUN.
- `done`  out  NUM_CH  single-cycle pulse with the final `clken` of ONESHOT or BURST.

## Operation
- Per channel:
  - Shadow registers: `sdiv`, `smode`, `sburst`, written by `cfg_wr`.
  - Active registers: `adiv`, `amode`, `aburst`.
  - Down-counter: `cnt[DIV_W]`.
  - Pulse counter: `pcnt[CNT_W+1]`.
  - State: IDLE or RUN.
- IDLE -> RUN:
  - Condition: `start[i]=1`, `stop[i]=0`, and the effective mode is not OFF.
  - Action: copy shadow to active, `cnt<=sdiv`, `pcnt<=0`.
- If `start[i]` is asserted while the effective mode is OFF, the channel stays IDLE.
- RUN, each edge:
  - If `cnt==0`: `clken<=1`, `cnt<=adiv`, `pcnt++`.
  - Otherwise: `cnt<=cnt-1`, `clken<=0`.
- CONT:
  - Runs until stopped.
  - `adiv<=sdiv` at every reload, so a divider change applies from the next period without a restart.
- ONESHOT:
  - First pulse edge: `clken<=1`, `done<=1`, RUN -> IDLE.
- BURST:
  - The pulse edge that completes `aburst` pulses (2^CNT_W if 0) sets `clken<=1`, `done<=1`, RUN -> IDLE.
  - `adiv`, `amode` and `aburst` stay frozen for the whole burst.
- `stop[i]` in RUN:
  - Next edge: RUN -> IDLE, `clken<=0`, no `done`.
  - `stop` takes priority over `start` and over a same-edge terminal pulse: no `clken`, no `done`.
- `start[i]` in RUN: restart. Reload shadow to active, `cnt<=sdiv`, `pcnt<=0`; no pulse on that edge.
- `cfg_wr` and `start` to the same channel on the same edge: start uses the newly written values (bypass).
- Writes to a RUN channel: `mode` and `burst` take effect at the next start; `div` behaves as listed per mode above.
- Channels are fully independent. Two channels with equal `div` started on the same edge pulse in lockstep.

## Timing
- Reset:
  - All outputs 0.
  - All state IDLE; shadow and active registers 0 (mode OFF).
  - `cnt` and `pcnt` are 0.
- Reset mid-operation:
  - Any edge with `PRESETn=0` forces the reset values above.
  - `start`, `stop` and `cfg_wr` are ignored on that edge.
  - No `done` is emitted.
- Start at edge E0: `active=1` after E0. First `clken=1` after edge E0+div+1, then every `div+1` cycles.
- `div=0`: `clken` is high every cycle from E0+1 while RUN.
- `active` falls on the same edge as the terminal `clken`/`done` rise. `clken` and `done` each stay high for exactly 1 cycle.
- `cnt` never wraps: the reload happens at 0.
- `pcnt` saturation cannot occur because its width is CNT_W+1.

## Test plan
- CONT period:
  - Stimulus: ch0 `div=3`, start at E0.
  - Required: `clken[0]` high after E4, E8, E12; `active[0]` stays 1; `done` never asserts.
- BURST count and wrap:
  - Stimulus: ch1 `div=1`, `burst=3`, start.
  - Required: exactly 3 pulses, 2 cycles apart; `done[1]` coincides with the 3rd; `active[1]` falls on the same edge.
  - Stimulus: repeat with `burst=0` and CNT_W=2.
  - Required: exactly 4 pulses.
- ONESHOT with `div=0`:
  - Stimulus: start at E0.
  - Required: a single `clken` and `done` after E1; back to IDLE.
- Priority:
  - Stimulus: ch2 CONT `div=2`; assert `stop` on the edge where `cnt==0`, plus `start` in the same cycle.
  - Required: no pulse, channel IDLE.
  - Stimulus: `start` alone while RUN.
  - Required: restart, next pulse `div+1` edges later.
- Shadow update:
  - Stimulus: ch3 CONT `div=5`; write `div=1` mid-period.
  - Required: the current period completes at 6 cycles, then 2-cycle periods.
  - Stimulus: a BURST write mid-burst.
  - Required: ignored until the next start.
- Reset and invalid config:
  - Stimulus: drive `PRESETn=0` for 1 cycle mid-burst.
  - Required: all outputs 0 on the next edge, no `done`.
  - Stimulus: `cfg_wr` with `cfg_ch=NUM_CH`.
  - Required: no register changes.
